// File: rtl/menu_sequencer.sv
// menu_sequencer: control-side state machine for the menu graphics path.
// Conditions the raw mode/start buttons (2-flop sync + debounce + press
// pulse), toggles 1P/2P selection in MENU, runs a timed COUNT_START..0
// countdown, pulses game_start on entry to PLAY and returns to MENU on
// game_over.
// Optional build macro: MENU_ABORT_EN -- when defined, a start press during
// the countdown aborts back to MENU.
module menu_sequencer #(
    parameter int COUNT_START     = 3,
    parameter int TICK_CYCLES     = 25000000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       btn_mode_raw,
    input  logic       btn_start_raw,
    input  logic       game_over,
    output logic       menu_active,
    output logic       countdown_active,
    output logic [7:0] countdown_value,
    output logic       game_mode_1p,
    output logic       game_start,
    output logic       game_running
);

    // The debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TICK_W = $clog2(TICK_CYCLES);

    typedef enum logic [1:0] {
        ST_MENU,
        ST_COUNTDOWN,
        ST_PLAY
    } state_t;

    logic [1:0] btn_raw;
    logic [1:0] press;
    logic       press_mode;
    logic       press_start;

    // Bit 0 is the mode button, bit 1 the start button.
    assign btn_raw     = {btn_start_raw, btn_mode_raw};
    assign press_mode  = press[0];
    assign press_start = press[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            level_reg;
            logic            press_reg;
            logic [DB_W-1:0] cnt_reg;

            // Synchronise, then accept a new level only after it has differed
            // from the debounced level for DEBOUNCE_CYCLES consecutive cycles.
            always_ff @(posedge pixel_clk or posedge reset) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg != level_reg) begin
                        if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                            level_reg <= sync2_reg;
                            cnt_reg   <= '0;
                            // Only the rising edge of the debounced level is a press.
                            press_reg <= sync2_reg;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [TICK_W-1:0] tick_reg, tick_next;
    logic [7:0]        value_reg, value_next;
    logic              mode_reg, mode_next;
    logic              start_reg, start_next;
    logic              menu_reg, countdown_reg, running_reg;
    logic              abort;

`ifdef MENU_ABORT_EN
    assign abort = press_start;
`else
    assign abort = 1'b0;
`endif

    // Next-state logic: mode selection in MENU, timed countdown, PLAY hold.
    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        value_next = value_reg;
        mode_next  = mode_reg;
        start_next = 1'b0;
        case (state_reg)
            ST_MENU: begin
                tick_next  = '0;
                value_next = 8'd0;
                // Start wins over a simultaneous mode press.
                if (press_start) begin
                    state_next = ST_COUNTDOWN;
                    value_next = 8'(COUNT_START);
                end else if (press_mode) begin
                    mode_next = ~mode_reg;
                end
            end
            ST_COUNTDOWN: begin
                if (abort) begin
                    state_next = ST_MENU;
                    value_next = 8'd0;
                    tick_next  = '0;
                end else if (tick_reg == TICK_W'(TICK_CYCLES - 1)) begin
                    tick_next = '0;
                    if (value_reg != 8'd0) begin
                        value_next = value_reg - 8'd1;
                    end else begin
                        // "GO" step finished: pulse coincides with first PLAY cycle.
                        state_next = ST_PLAY;
                        start_next = 1'b1;
                    end
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end
            ST_PLAY: begin
                tick_next  = '0;
                value_next = 8'd0;
                if (game_over) begin
                    state_next = ST_MENU;
                end
            end
            default: begin
                state_next = ST_MENU;
                tick_next  = '0;
                value_next = 8'd0;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_MENU;
            tick_reg      <= '0;
            value_reg     <= 8'd0;
            mode_reg      <= 1'b1;
            start_reg     <= 1'b0;
            menu_reg      <= 1'b1;
            countdown_reg <= 1'b0;
            running_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tick_reg      <= tick_next;
            value_reg     <= value_next;
            mode_reg      <= mode_next;
            start_reg     <= start_next;
            menu_reg      <= (state_next == ST_MENU);
            countdown_reg <= (state_next == ST_COUNTDOWN);
            running_reg   <= (state_next == ST_PLAY);
        end
    end

    assign menu_active      = menu_reg;
    assign countdown_active = countdown_reg;
    assign countdown_value  = value_reg;
    assign game_mode_1p     = mode_reg;
    assign game_start       = start_reg;
    assign game_running     = running_reg;

endmodule

// File: tb/tb_menu_sequencer.sv
// tb_menu_sequencer: table-driven vectors, hand-written countdown/reset/abort
// sequences and a randomized run, all checked against a cycle-level model.
module tb_menu_sequencer;

    localparam int CS = 3;
    localparam int T  = 10;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode_raw = 1'b0;
    logic       btn_start_raw = 1'b0;
    logic       game_over = 1'b0;
    logic       menu_active;
    logic       countdown_active;
    logic [7:0] countdown_value;
    logic       game_mode_1p;
    logic       game_start;
    logic       game_running;

    int total = 0;
    int bad = 0;

    menu_sequencer #(
        .COUNT_START(CS),
        .TICK_CYCLES(T),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .pixel_clk(clk),
        .reset(reset),
        .btn_mode_raw(btn_mode_raw),
        .btn_start_raw(btn_start_raw),
        .game_over(game_over),
        .menu_active(menu_active),
        .countdown_active(countdown_active),
        .countdown_value(countdown_value),
        .game_mode_1p(game_mode_1p),
        .game_start(game_start),
        .game_running(game_running)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 menu, 1 countdown, 2 play. The countdown is
    // tracked as elapsed cycles; the displayed number is derived from it.
    int m_d1[2], m_d2[2], m_lvl[2], m_run[2];
    bit m_press[2];
    int m_phase, m_elapsed;
    bit m_1p, m_start;

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0; m_run[b] = 0; m_press[b] = 0;
        end
        m_phase = 0; m_elapsed = 0; m_1p = 1; m_start = 0;
    endfunction

    function automatic void model_edge(input bit mode, input bit start, input bit go);
        bit pm, ps;
        int raw[2];
        int seen;
        pm = m_press[0];
        ps = m_press[1];
        raw[0] = int'(mode);
        raw[1] = int'(start);
        for (int b = 0; b < 2; b++) begin
            // Debouncer sees the raw level from two clocks earlier.
            seen = m_d2[b];
            m_d2[b] = m_d1[b];
            m_d1[b] = raw[b];
            m_press[b] = 0;
            if (seen != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    m_lvl[b] = seen;
                    m_run[b] = 0;
                    m_press[b] = (seen == 1);
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_start = 0;
        case (m_phase)
            0: begin
                if (ps) begin
                    m_phase = 1; m_elapsed = 0;
                end else if (pm) begin
                    m_1p = !m_1p;
                end
            end
            1: begin
`ifdef MENU_ABORT_EN
                if (ps) begin
                    m_phase = 0;
                end else
`endif
                begin
                    m_elapsed++;
                    if (m_elapsed == (CS + 1) * T) begin
                        m_phase = 2; m_start = 1;
                    end
                end
            end
            default: if (go) m_phase = 0;
        endcase
    endfunction

    function automatic int model_value();
        return (m_phase == 1) ? CS - m_elapsed / T : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [12:0] act, exp;
        act = {menu_active, countdown_active, countdown_value, game_mode_1p, game_start, game_running};
        exp = {m_phase == 0, m_phase == 1, 8'(model_value()), m_1p, m_start, m_phase == 2};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL model t=%0t got menu/cd/val/1p/gs/run=%b expected %b", $time, act, exp);
        end
    endtask

    task automatic step(input bit m, input bit s, input bit g);
        btn_mode_raw = m;
        btn_start_raw = s;
        game_over = g;
        @(posedge clk);
        model_edge(m, s, g);
        #1;
        compare_model();
    endtask

    task automatic chk_reset_values(input string nm);
        chk({nm, "_menu"}, int'(menu_active), 1);
        chk({nm, "_cd"}, int'(countdown_active), 0);
        chk({nm, "_val"}, int'(countdown_value), 0);
        chk({nm, "_1p"}, int'(game_mode_1p), 1);
        chk({nm, "_gs"}, int'(game_start), 0);
        chk({nm, "_run"}, int'(game_running), 0);
    endtask

    // Asserts reset between clock edges so the async path is what is seen.
    task automatic do_reset_mid();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit mode; bit start; bit go; int cycles;
        bit e_menu; bit e_cd; int e_val; bit e_1p; bit e_run;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    initial begin
        int n, gs_cnt;
        int hold[2];
        bit lvl[2];

        // mode start go cycles | menu cd val 1p run
        vecs[0]  = '{0, 0, 0, 100, 1, 0, 0, 1, 0};  // idle after reset
        vecs[1]  = '{1, 0, 0, 3,   1, 0, 0, 1, 0};  // short bounce
        vecs[2]  = '{0, 0, 0, 10,  1, 0, 0, 1, 0};  // no toggle
        vecs[3]  = '{1, 0, 0, 20,  1, 0, 0, 0, 0};  // held: one toggle
        vecs[4]  = '{0, 0, 0, 10,  1, 0, 0, 0, 0};  // release: nothing
        vecs[5]  = '{1, 0, 0, 10,  1, 0, 0, 1, 0};  // second press
        vecs[6]  = '{0, 0, 0, 10,  1, 0, 0, 1, 0};
        vecs[7]  = '{0, 1, 0, 8,   0, 1, 3, 1, 0};  // start -> countdown
        vecs[8]  = '{0, 0, 0, 10,  0, 1, 2, 1, 0};
        vecs[9]  = '{0, 0, 0, 30,  0, 0, 0, 1, 1};  // reaches play
        vecs[10] = '{1, 1, 0, 20,  0, 0, 0, 1, 1};  // buttons ignored in play
        vecs[11] = '{0, 0, 1, 1,   1, 0, 0, 1, 0};  // game_over -> menu
        vecs[12] = '{0, 0, 0, 10,  1, 0, 0, 1, 0};
        vecs[13] = '{1, 1, 0, 8,   0, 1, 3, 1, 0};  // simultaneous: start wins
        vecs[14] = '{0, 0, 0, 50,  0, 0, 0, 1, 1};
        vecs[15] = '{0, 0, 1, 1,   1, 0, 0, 1, 0};
        vecs[16] = '{0, 0, 1, 1,   1, 0, 0, 1, 0};  // game_over in menu ignored

        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_values("held_rst");
        reset = 1'b0;
        #1;
        chk_reset_values("post_rst");

        for (int i = 0; i < NV; i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].mode, vecs[i].start, vecs[i].go);
            chk($sformatf("vec%0d_menu", i), int'(menu_active), int'(vecs[i].e_menu));
            chk($sformatf("vec%0d_cd", i), int'(countdown_active), int'(vecs[i].e_cd));
            chk($sformatf("vec%0d_val", i), int'(countdown_value), vecs[i].e_val);
            chk($sformatf("vec%0d_1p", i), int'(game_mode_1p), int'(vecs[i].e_1p));
            chk($sformatf("vec%0d_run", i), int'(game_running), int'(vecs[i].e_run));
            $display("vec %0d: menu=%b cd=%b val=%0d 1p=%b run=%b", i, menu_active,
                     countdown_active, countdown_value, game_mode_1p, game_running);
        end

        // Cycle-exact countdown: each value held T cycles, one-cycle game_start.
        for (int c = 0; c < 10; c++) step(0, 0, 0);
        n = 0;
        while (!countdown_active && n < 20) begin step(0, 1, 0); n++; end
        chk("cd_enter", int'(countdown_active), 1);
        for (int v = CS; v >= 0; v--) begin
            for (int c = 0; c < T; c++) begin
                chk($sformatf("cd_val%0d_c%0d", v, c), int'(countdown_value), v);
                chk($sformatf("cd_act%0d_c%0d", v, c), int'(countdown_active), 1);
                step(0, 0, 0);
            end
        end
        chk("gs_high", int'(game_start), 1);
        chk("play_run", int'(game_running), 1);
        chk("play_menu", int'(menu_active), 0);
        step(0, 0, 0);
        chk("gs_low", int'(game_start), 0);
        step(0, 0, 1);
        chk("over_menu", int'(menu_active), 1);
        $display("countdown sequence: done");

        // Reset asserted while countdown shows 2.
        for (int c = 0; c < 10; c++) step(0, 0, 0);
        n = 0;
        while (!countdown_active && n < 20) begin step(0, 1, 0); n++; end
        n = 0;
        while (countdown_value != 8'd2 && n < 40) begin step(0, 0, 0); n++; end
        chk("rst_at2_val", int'(countdown_value), 2);
        do_reset_mid();
        gs_cnt = 0;
        for (int c = 0; c < 50; c++) begin step(0, 0, 0); gs_cnt += int'(game_start); end
        chk("rst_no_gs", gs_cnt, 0);
        $display("reset mid-countdown: done");

        // Start press while countdown shows 2.
        n = 0;
        while (!countdown_active && n < 20) begin step(0, 1, 0); n++; end
        n = 0;
        while (countdown_value != 8'd2 && n < 40) begin step(0, 0, 0); n++; end
        chk("abort_at2_val", int'(countdown_value), 2);
`ifdef MENU_ABORT_EN
        n = 0;
        while (!menu_active && n < 20) begin step(0, 1, 0); n++; end
        chk("abort_menu", int'(menu_active), 1);
        chk("abort_val", int'(countdown_value), 0);
        gs_cnt = 0;
        for (int c = 0; c < 50; c++) begin step(0, 0, 0); gs_cnt += int'(game_start); end
        chk("abort_no_gs", gs_cnt, 0);
`else
        for (int c = 0; c < 12; c++) step(0, 1, 0);
        chk("noabort_cd", int'(countdown_active), 1);
        n = 0;
        while (!game_start && n < 60) begin step(0, 0, 0); n++; end
        chk("noabort_gs", int'(game_start), 1);
        step(0, 0, 1);
`endif
        $display("start during countdown: done");

        // Randomized button levels with bounces and sporadic game_over.
        hold[0] = 0; hold[1] = 0; lvl[0] = 0; lvl[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 2; b++) begin
                if (hold[b] == 0) begin
                    lvl[b] = bit'($urandom_range(0, 1));
                    hold[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(5, 20));
                end
                hold[b]--;
            end
            step(lvl[0], lvl[1], $urandom_range(0, 39) == 0);
        end
        $display("random run: done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
